// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: load-use bubbles, branch flushes and memory-access freeze for a 5-stage pipeline
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             Branch_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Pipe_Hold_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_rdata_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [7:0] wait_cnt;
  logic lu, mem_stall, freeze, pending;
  always_comb begin
    pending = EXMEM_MemRead_i || EXMEM_MemWrite_i;
    lu = IDEX_MemRead_i && IDEX_RDaddr_i != 5'd0 &&
         (IDEX_RDaddr_i == IFID_RS1addr_i || IDEX_RDaddr_i == IFID_RS2addr_i);
    mem_stall = state == WAIT || (state == IDLE && pending);
    freeze = rst_i || !start_i || mem_stall;
    PCWrite_o = !freeze && !lu;
    IFID_Write_o = !freeze && !lu;
    Pipe_Hold_o = freeze;
    IDEX_Bubble_o = !freeze && lu;
    IFID_Flush_o = !freeze && !lu && Branch_i;
  end
  // DONE is the single unfrozen cycle that lets the finished access retire into MEM_WB
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      wait_cnt <= '0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_rdata_o <= '0;
      error_o <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (start_i && !PCWrite_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (state == IDLE) begin
        if (start_i && pending) begin
          state <= WAIT;
          mem_req_o <= 1'b1;
          mem_we_o <= EXMEM_MemWrite_i;
          wait_cnt <= '0;
        end
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (mem_ack_i) begin
          if (!mem_we_o) mem_rdata_o <= mem_rdata_i;
          mem_req_o <= 1'b0;
          mem_we_o <= 1'b0;
          state <= DONE;
        end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
          mem_req_o <= 1'b0;
          mem_we_o <= 1'b0;
          mem_rdata_o <= '0;
          error_o <= 1'b1;
          state <= DONE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed plus random stimulus, transaction-level model feeding a scoreboard queue
module tb_pipeline_stall_ctrl;
  localparam int TO = 16;
  localparam int CW = 5;
  logic clk = 0, rst_i = 1, start_i = 0, IDEX_MemRead_i = 0, Branch_i = 0;
  logic EXMEM_MemRead_i = 0, EXMEM_MemWrite_i = 0, mem_ack_i = 0;
  logic [4:0] IDEX_RDaddr_i = 0, IFID_RS1addr_i = 0, IFID_RS2addr_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Pipe_Hold_o, mem_req_o, mem_we_o, error_o;
  logic [31:0] mem_rdata_o;
  logic [CW-1:0] stall_cnt_o;
  always #5 clk = ~clk;
  pipeline_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_RDaddr_i(IDEX_RDaddr_i), .IFID_RS1addr_i(IFID_RS1addr_i), .IFID_RS2addr_i(IFID_RS2addr_i),
    .Branch_i(Branch_i), .EXMEM_MemRead_i(EXMEM_MemRead_i), .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .PCWrite_o(PCWrite_o), .IFID_Write_o(IFID_Write_o),
    .IFID_Flush_o(IFID_Flush_o), .IDEX_Bubble_o(IDEX_Bubble_o), .Pipe_Hold_o(Pipe_Hold_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_rdata_o(mem_rdata_o), .error_o(error_o),
    .stall_cnt_o(stall_cnt_o));
  typedef struct packed {
    logic rst, start, imr; logic [4:0] rd, rs1, rs2; logic br, mr, mw, ack; logic [31:0] data;
  } stim_t;
  typedef struct packed {
    logic pcw, ifw, fl, bub, hold, req, we; logic [31:0] rdata; logic err; logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  bit drv_done = 0;
  // model state: access phase 0=none 1=requesting 2=retiring
  int phase = 0, waited = 0, cnt = 0;
  bit m_req = 0, m_we = 0, m_err = 0;
  logic [31:0] m_rdata = 0;
  task automatic step(input stim_t s);
    exp_t e;
    bit lu, frozen, go;
    @(posedge clk);
    #1;
    rst_i = s.rst; start_i = s.start; IDEX_MemRead_i = s.imr; IDEX_RDaddr_i = s.rd;
    IFID_RS1addr_i = s.rs1; IFID_RS2addr_i = s.rs2; Branch_i = s.br; EXMEM_MemRead_i = s.mr;
    EXMEM_MemWrite_i = s.mw; mem_ack_i = s.ack; mem_rdata_i = s.data;
    lu = s.imr && s.rd != 0 && (s.rd == s.rs1 || s.rd == s.rs2);
    frozen = s.rst || !s.start || phase == 1 || (phase == 0 && (s.mr || s.mw));
    go = !frozen && !lu;
    e = '{pcw: go, ifw: go, fl: go && s.br, bub: !frozen && lu, hold: frozen,
          req: m_req, we: m_we, rdata: m_rdata, err: m_err, cnt: CW'(cnt)};
    sb.push_back(e);
    if (s.rst) begin
      phase = 0; waited = 0; cnt = 0; m_req = 0; m_we = 0; m_err = 0; m_rdata = 0;
    end else begin
      if (s.start && !go && cnt < (1 << CW) - 1) cnt++;
      if (phase == 0) begin
        if (s.start && (s.mr || s.mw)) begin phase = 1; waited = 0; m_req = 1; m_we = s.mw; end
      end else if (phase == 1) begin
        if (s.ack) begin
          if (!m_we) m_rdata = s.data;
          m_req = 0; m_we = 0; phase = 2;
        end else if (waited == TO - 1) begin
          m_req = 0; m_we = 0; m_rdata = 0; m_err = 1; phase = 2;
        end else waited++;
      end else phase = 0;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("PCWrite", 32'(PCWrite_o), 32'(e.pcw));
        chk("IFID_Write", 32'(IFID_Write_o), 32'(e.ifw));
        chk("IFID_Flush", 32'(IFID_Flush_o), 32'(e.fl));
        chk("IDEX_Bubble", 32'(IDEX_Bubble_o), 32'(e.bub));
        chk("Pipe_Hold", 32'(Pipe_Hold_o), 32'(e.hold));
        chk("mem_req", 32'(mem_req_o), 32'(e.req));
        chk("mem_we", 32'(mem_we_o), 32'(e.we));
        chk("mem_rdata", mem_rdata_o, e.rdata);
        chk("error", 32'(error_o), 32'(e.err));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(e.cnt));
      end
    end
  end
  initial begin
    stim_t s, idle;
    idle = '0;
    idle.start = 1;
    s = '0; s.rst = 1;
    repeat (2) step(s);
    repeat (3) step(idle);
    s = idle; s.imr = 1; s.rd = 5; s.rs2 = 5; step(s);
    step(idle);
    s = idle; s.imr = 1; s.rd = 0; step(s);
    s = idle; s.mr = 1;
    for (int i = 0; i < 5; i++) begin
      s.ack = (i == 3); s.data = (i == 3) ? 32'hDEADBEEF : 32'h0;
      step(s);
    end
    step(idle);
    s = idle; s.mw = 1;
    repeat (18) step(s);
    repeat (2) step(idle);
    s = idle; s.imr = 1; s.rd = 7; s.rs1 = 7; s.br = 1; step(s);
    s = idle; s.br = 1; step(s);
    s = idle; s.mr = 1;
    repeat (3) step(s);
    s.rst = 1; step(s);
    s = idle; s.ack = 1; s.data = 32'h12345678; step(s);
    repeat (2) step(idle);
    repeat (40) begin
      s = idle; s.imr = 1; s.rd = 3; s.rs1 = 3; step(s);
    end
    for (int i = 0; i < 4000; i++) begin
      s.rst = ($urandom % 200) == 0;
      s.start = ($urandom % 8) != 0;
      s.imr = $urandom % 2;
      s.rd = 5'($urandom % 4);
      s.rs1 = 5'($urandom % 4);
      s.rs2 = 5'($urandom % 4);
      s.br = ($urandom % 3) == 0;
      s.mr = ($urandom % 4) == 0;
      s.mw = ($urandom % 5) == 0;
      s.ack = ($urandom % 6) == 0;
      s.data = $urandom;
      step(s);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
